// File: rtl/motor_port_sequencer_if.sv
// rtl/motor_port_sequencer_if.sv - signal bundle between mode mux, DSHOT controller, USB UART and motor pads
interface motor_port_sequencer_if;
  logic       i_mode_req;
  logic [1:0] i_motor_sel;
  logic       i_dshot_busy;
  logic [3:0] i_dshot_out;
  logic [3:0] i_motor_i;
  logic       i_usb_rx;
  logic       o_usb_tx;
  logic [3:0] o_motor_o;
  logic [3:0] o_motor_oe;
  logic       o_dshot_en;
  logic       o_mode_active;
  logic       o_switching;

  modport master (
    output i_mode_req, i_motor_sel, i_dshot_busy, i_dshot_out, i_motor_i, i_usb_rx,
    input  o_usb_tx, o_motor_o, o_motor_oe, o_dshot_en, o_mode_active, o_switching
  );

  modport slave (
    input  i_mode_req, i_motor_sel, i_dshot_busy, i_dshot_out, i_motor_i, i_usb_rx,
    output o_usb_tx, o_motor_o, o_motor_oe, o_dshot_en, o_mode_active, o_switching
  );
endinterface

// File: rtl/motor_port_sequencer.sv
// rtl/motor_port_sequencer.sv - switches motor pads between DSHOT drive and half-duplex USB passthrough
module motor_port_sequencer #(
  parameter int GUARD_CYCLES = 7200,
  parameter int HOLD_CYCLES  = 6250
) (
  input logic                   i_sys_clk,
  input logic                   i_rst,
  motor_port_sequencer_if.slave bus
);
  localparam int GW = $clog2(GUARD_CYCLES) + 1;
  localparam int HW = $clog2(HOLD_CYCLES) + 1;
  localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD_CYCLES);
  localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLD_CYCLES);

  typedef enum logic [2:0] {
    ST_DSHOT, ST_DRAIN, ST_GUARD_PT, ST_PASSTHRU, ST_GUARD_DS
  } state_t;

  typedef enum logic {SUB_LISTEN, SUB_TALK} sub_t;

  state_t        state_q, state_d;
  sub_t          sub_q, sub_d;
  logic [GW-1:0] guard_q, guard_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [1:0]    sel_q, sel_d;
  logic          mode_active_q, mode_active_d;
  logic [1:0]    rx_sync;
  logic [3:0]    mi_s1, mi_s2;
  logic          rx_s;
  logic          dshot_en;
  logic [3:0]    motor_o, motor_oe;
  logic          usb_tx;

  assign rx_s = rx_sync[1];

  // Two-flop synchronizers for the asynchronous USB RX and motor pad inputs; lines idle high
  always_ff @(posedge i_sys_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_sync <= 2'b11;
      mi_s1   <= 4'hF;
      mi_s2   <= 4'hF;
    end else begin
      rx_sync <= {rx_sync[0], bus.i_usb_rx};
      mi_s1   <= bus.i_motor_i;
      mi_s2   <= mi_s1;
    end
  end

  // Mode state, guard/hold counters, latched passthrough motor and registered mode flag
  always_ff @(posedge i_sys_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= ST_GUARD_DS;
      sub_q         <= SUB_LISTEN;
      guard_q       <= GUARD_LOAD;
      hold_q        <= '0;
      sel_q         <= '0;
      mode_active_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      sub_q         <= sub_d;
      guard_q       <= guard_d;
      hold_q        <= hold_d;
      sel_q         <= sel_d;
      mode_active_q <= mode_active_d;
    end
  end

  // Next-state, counter updates and pad/UART output steering per mode
  always_comb begin
    state_d  = state_q;
    sub_d    = sub_q;
    guard_d  = guard_q;
    hold_d   = hold_q;
    sel_d    = sel_q;
    dshot_en = 1'b0;
    motor_oe = 4'hF;
    motor_o  = 4'h0;
    usb_tx   = 1'b1;
    case (state_q)
      ST_DSHOT: begin
        dshot_en = 1'b1;
        motor_o  = bus.i_dshot_out;
        if (!bus.i_mode_req) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        motor_o = bus.i_dshot_out;
        if (!bus.i_dshot_busy) begin
          state_d = ST_GUARD_PT;
          guard_d = GUARD_LOAD;
          sel_d   = bus.i_motor_sel;
        end
      end
      ST_GUARD_PT: begin
        // Selected line parked high (UART idle) while the ESC settles
        motor_o = 4'b0001 << sel_q;
        if (guard_q <= GW'(1)) begin
          guard_d = '0;
          state_d = ST_PASSTHRU;
        end else begin
          guard_d = guard_q - 1'b1;
        end
      end
      ST_PASSTHRU: begin
        if (sub_q == SUB_LISTEN) begin
          motor_oe[sel_q] = 1'b0;
          usb_tx          = mi_s2[sel_q];
          // Mode exit only from LISTEN so an in-flight host byte is never cut
          if (bus.i_mode_req) begin
            state_d = ST_GUARD_DS;
            guard_d = GUARD_LOAD;
          end else if (!rx_s) begin
            sub_d  = SUB_TALK;
            hold_d = HOLD_LOAD;
          end
        end else begin
          motor_o[sel_q] = rx_s;
          if (!rx_s) begin
            hold_d = HOLD_LOAD;
          end else if (hold_q <= HW'(1)) begin
            hold_d = '0;
            sub_d  = SUB_LISTEN;
          end else begin
            hold_d = hold_q - 1'b1;
          end
        end
      end
      ST_GUARD_DS: begin
        if (guard_q <= GW'(1)) begin
          guard_d = '0;
          state_d = ST_DSHOT;
        end else begin
          guard_d = guard_q - 1'b1;
        end
      end
      default: state_d = ST_GUARD_DS;
    endcase
    mode_active_d = (state_d == ST_DSHOT) || (state_d == ST_DRAIN) || (state_d == ST_GUARD_DS);
  end

  assign bus.o_dshot_en    = dshot_en;
  assign bus.o_motor_oe    = motor_oe;
  assign bus.o_motor_o     = motor_o;
  assign bus.o_usb_tx      = usb_tx;
  assign bus.o_mode_active = mode_active_q;
  assign bus.o_switching   = (state_q == ST_DRAIN) || (state_q == ST_GUARD_PT) ||
                             (state_q == ST_GUARD_DS);
endmodule

// File: doc/motor_port_sequencer.md
MOTOR_PORT_SEQUENCER -- requirements
Module: motor_port_sequencer

Interface
REQ-001 SHALL have parameter GUARD_CYCLES, 7200, idle guard time between modes (100 us at 72 MHz).
REQ-002 SHALL have parameter HOLD_CYCLES, 6250, host-TX hold after last usb_rx low (10 bit times at 115200).
REQ-003 SHALL have port i_sys_clk  in  1  system clock (72 MHz); the block uses one clock, all logic on its rising edge.
REQ-004 SHALL have port i_rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port i_mode_req  in  1  requested mode from mux register: 1=DSHOT, 0=passthrough.
REQ-006 SHALL have port i_motor_sel  in  2  passthrough target motor index (0..3).
REQ-007 SHALL have port i_dshot_busy  in  1  DSHOT controller frame in progress.
REQ-008 SHALL have port i_dshot_out  in  4  DSHOT controller per-motor outputs.
REQ-009 SHALL have port i_motor_i  in  4  motor pad input values (asynchronous).
REQ-010 SHALL have port i_usb_rx  in  1  USB UART RX from PC (asynchronous).
REQ-011 SHALL have port o_usb_tx  out  1  USB UART TX to PC.
REQ-012 SHALL have port o_motor_o  out  4  motor pad output values.
REQ-013 SHALL have port o_motor_oe  out  4  motor pad output enables (1=drive).
REQ-014 SHALL have port o_dshot_en  out  1  permission for DSHOT controller to start frames.
REQ-015 SHALL have port o_mode_active  out  1  active mode: 1=DSHOT, 0=passthrough, registered.
REQ-016 SHALL have port o_switching  out  1  high in DRAIN and guard states.

Function
REQ-017 SHALL synchronize i_usb_rx and each i_motor_i bit through 2 flops (reset value 1) before use.
REQ-018 SHALL implement states DSHOT, DRAIN, GUARD_PT, PASSTHRU, GUARD_DS.
REQ-019 DSHOT: o_dshot_en=1, o_motor_oe=4'hF, o_motor_o=i_dshot_out, o_usb_tx=1; i_mode_req=0 -> DRAIN.
REQ-020 DRAIN: o_dshot_en=0 from first DRAIN cycle, outputs still follow i_dshot_out; i_dshot_busy=0 -> GUARD_PT, else stay.
REQ-021 GUARD_PT: on entry latch i_motor_sel into sel_q, load counter; drive all motors, sel_q high, others low; after exactly GUARD_CYCLES cycles -> PASSTHRU.
REQ-022 PASSTHRU: non-selected motors oe=1, o=0; sel_q changes to i_motor_sel ignored until next entry.
REQ-023 PASSTHRU sub-state LISTEN: sel_q motor oe=0; o_usb_tx=synced motor input of sel_q.
REQ-024 LISTEN -> TALK when synced usb_rx=0; TALK: sel_q motor oe=1, o=synced usb_rx, o_usb_tx=1 (echo suppressed).
REQ-025 TALK: hold counter reloads to HOLD_CYCLES on every synced usb_rx=0 cycle; returns to LISTEN when counter reaches 0 with usb_rx=1.
REQ-026 PASSTHRU with i_mode_req=1 -> GUARD_DS only while sub-state LISTEN; in TALK, exit deferred until LISTEN.
REQ-027 GUARD_DS: all motors oe=1, o=0, o_dshot_en=0, o_usb_tx=1; after exactly GUARD_CYCLES cycles -> DSHOT.
REQ-028 i_mode_req changes during DRAIN, GUARD_PT or GUARD_DS SHALL NOT abort the sequence; re-evaluated in the next stable state.
REQ-029 o_mode_active SHALL be 1 in DSHOT, DRAIN, GUARD_DS and 0 in GUARD_PT, PASSTHRU.
REQ-030 Counters SHALL be sized by $clog2 of their parameter +1 and SHALL NOT wrap.

Reset
REQ-031 During and after i_rst: state=GUARD_DS, counter=GUARD_CYCLES, o_dshot_en=0, o_motor_oe=4'hF, o_motor_o=0, o_usb_tx=1, o_mode_active=1, o_switching=1, sub-state LISTEN.
REQ-032 Reset asserted mid-TALK or mid-guard SHALL take effect asynchronously with the values of REQ-031.

Verification (GUARD_CYCLES=16, HOLD_CYCLES=8)
REQ-033 Release reset, i_mode_req=1 -> o_dshot_en rises after 16 cycles, o_motor_o tracks i_dshot_out.
REQ-034 In DSHOT, i_dshot_busy=1, i_mode_req->0 -> o_dshot_en=0 next cycle; state holds DRAIN until busy=0, then 16 guard cycles, motor sel high.
REQ-035 PASSTHRU sel=2, usb_rx pulsed low 3 cycles -> oe=4'hF, motor2 follows usb_rx, o_usb_tx=1; LISTEN 8 cycles after usb_rx high.
REQ-036 LISTEN, motor2 input toggles -> o_usb_tx follows after 2-cycle sync; oe=4'b1011.
REQ-037 i_mode_req->1 mid-TALK -> remains PASSTHRU until LISTEN, then GUARD_DS all low 16 cycles, then DSHOT.
REQ-038 i_rst asserted in TALK -> outputs equal REQ-031 values without waiting for a clock edge.
